// File: rtl/qvalue_argmax_scanner.sv
// qvalue_argmax_scanner: scans the first N qValue words on the node memory
// port, picks the largest one (ties keep the lowest index), fetches the
// matching neighborID, and writes both back into the better_qvalue and
// nextsinks slots.
module qvalue_argmax_scanner (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    input  logic [6:0]  count,
    output logic        busy,
    output logic        done,
    output logic [5:0]  best_idx,
    output logic [15:0] best_q,
    output logic [15:0] best_id,
    output logic [15:0] mem_addr,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [15:0] Q_BASE    = 16'h01C8;
    localparam logic [15:0] ID_BASE   = 16'h0048;
    localparam logic [15:0] QOUT_ADDR = 16'h0710;
    localparam logic [15:0] NEXT_ADDR = 16'h0700;
    localparam logic [6:0]  MAX_N     = 7'd64;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_FETCH_ID = 3'd2,
        S_WR_Q     = 3'd3,
        S_WR_ID    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t      state_r;
    logic [5:0]  idx_r;
    logic [6:0]  n_r;
    logic [5:0]  best_idx_r;
    logic [15:0] best_q_r;
    logic [15:0] best_id_r;
    logic        busy_r;
    logic        done_r;
    logic        last_s;
    logic        better_s;

    // Scan position and comparison decode for the current SCAN cycle.
    always_comb begin
        last_s   = ({1'b0, idx_r} == (n_r - 7'd1));
        better_s = (idx_r == 6'd0) || (mem_rdata > best_q_r);
    end

    // Sequencer: state, scan counters, running maximum and status flags.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_r    <= S_IDLE;
            idx_r      <= 6'd0;
            n_r        <= 7'd0;
            best_idx_r <= 6'd0;
            best_q_r   <= 16'h0000;
            best_id_r  <= 16'h0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy_r <= 1'b1;
                        if (count != 7'd0) begin
                            n_r     <= (count > MAX_N) ? MAX_N : count;
                            idx_r   <= 6'd0;
                            state_r <= S_SCAN;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (better_s) begin
                        best_q_r   <= mem_rdata;
                        best_idx_r <= idx_r;
                    end else begin
                        best_q_r   <= best_q_r;
                    end
                    if (last_s) begin
                        state_r <= S_FETCH_ID;
                    end else begin
                        idx_r   <= idx_r + 6'd1;
                    end
                end
                S_FETCH_ID: begin
                    best_id_r <= mem_rdata;
                    state_r   <= S_WR_Q;
                end
                S_WR_Q: begin
                    state_r <= S_WR_ID;
                end
                S_WR_ID: begin
                    done_r  <= 1'b1;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port decode from the current state and registers.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_wr_en = 1'b0;
        mem_wdata = 16'h0000;
        case (state_r)
            S_SCAN: begin
                mem_addr = Q_BASE + {9'd0, idx_r, 1'b0};
            end
            S_FETCH_ID: begin
                mem_addr = ID_BASE + {9'd0, best_idx_r, 1'b0};
            end
            S_WR_Q: begin
                mem_addr  = QOUT_ADDR;
                mem_wr_en = 1'b1;
                mem_wdata = best_q_r;
            end
            S_WR_ID: begin
                mem_addr  = NEXT_ADDR;
                mem_wr_en = 1'b1;
                mem_wdata = best_id_r;
            end
            default: begin
                mem_addr  = 16'h0000;
                mem_wr_en = 1'b0;
                mem_wdata = 16'h0000;
            end
        endcase
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign best_idx = best_idx_r;
    assign best_q   = best_q_r;
    assign best_id  = best_id_r;

endmodule

// File: tb/tb_qvalue_argmax_scanner.sv
// Self-checking bench for qvalue_argmax_scanner: byte-addressed memory model,
// argmax reference model and a scoreboard of expected scan results.
module tb_qvalue_argmax_scanner;

    localparam logic [15:0] Q_BASE    = 16'h01C8;
    localparam logic [15:0] ID_BASE   = 16'h0048;
    localparam logic [15:0] QOUT_ADDR = 16'h0710;
    localparam logic [15:0] NEXT_ADDR = 16'h0700;

    logic        clock;
    logic        nrst;
    logic        start;
    logic [6:0]  count;
    logic        busy;
    logic        done;
    logic [5:0]  best_idx;
    logic [15:0] best_q;
    logic [15:0] best_id;
    logic [15:0] mem_addr;
    logic        mem_wr_en;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [7:0]  mem [0:65535] = '{default: 8'h00};
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [15:0] pl_data;
    int          wr_cnt = 0;

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] q;
        logic [15:0] id;
        int          lat;
        int          wr;
        bit          chk_mem;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    logic [5:0]  m_idx = 6'd0;
    logic [15:0] m_q   = 16'h0000;
    logic [15:0] m_id  = 16'h0000;

    qvalue_argmax_scanner dut (
        .clock     (clock),
        .nrst      (nrst),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .best_idx  (best_idx),
        .best_q    (best_q),
        .best_id   (best_id),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] rd_a1;
    assign rd_a1     = mem_addr + 16'd1;
    assign mem_rdata = {mem[mem_addr], mem[rd_a1]};

    // Memory write port: DUT writes plus bench preload writes.
    always @(posedge clock) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata[15:8];
            mem[rd_a1]    <= mem_wdata[7:0];
            wr_cnt        <= wr_cnt + 1;
        end else if (pl_en) begin
            mem[pl_addr]         <= pl_data[15:8];
            mem[pl_addr + 16'd1] <= pl_data[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        logic [15:0] a1;
        a1 = a + 16'd1;
        return {mem[a], mem[a1]};
    endfunction

    // Runs one scan: models the expected result, pushes it, then waits for
    // done and compares latency, outputs, write count and written memory.
    task automatic run_scan(input logic [6:0] cnt, input bit hold);
        exp_t e;
        exp_t g;
        int   n;
        int   cyc;
        int   wr0;
        logic [15:0] q;
        n = (cnt > 7'd64) ? 64 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            q = rd(Q_BASE + 16'(2 * i));
            if (i == 0 || q > m_q) begin
                m_q   = q;
                m_idx = 6'(i);
            end
        end
        if (n > 0) m_id = rd(ID_BASE + {9'd0, m_idx, 1'b0});
        e.idx = m_idx; e.q = m_q; e.id = m_id;
        e.lat = (n == 0) ? 1 : n + 4;
        e.wr  = (n == 0) ? 0 : 2;
        e.chk_mem = (n > 0);
        sb.push_back(e);

        wr0   = wr_cnt;
        start = 1'b1;
        count = cnt;
        tick();
        if (!hold) start = 1'b0;
        cyc = 1;
        check("busy_rise", {31'd0, busy}, 32'd1);
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        g = sb.pop_front();
        check("done_latency", cyc, g.lat);
        check("best_idx", {26'd0, best_idx}, {26'd0, g.idx});
        check("best_q", {16'd0, best_q}, {16'd0, g.q});
        check("best_id", {16'd0, best_id}, {16'd0, g.id});
        check("write_count", wr_cnt - wr0, g.wr);
        if (g.chk_mem) begin
            check("mem_qout", {16'd0, rd(QOUT_ADDR)}, {16'd0, g.q});
            check("mem_next", {16'd0, rd(NEXT_ADDR)}, {16'd0, g.id});
        end
        tick();
        check("done_pulse_end", {31'd0, done}, 32'd0);
        check("busy_fall", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        nrst  = 1'b0;
        start = 1'b0;
        count = 7'd0;
        pl_en = 1'b0;
        pl_addr = 16'h0000;
        pl_data = 16'h0000;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_best_q", {16'd0, best_q}, 32'd0);
        #20;
        tick();
        nrst = 1'b1;
        tick();

        // Ascending pattern: last entry wins.
        for (int i = 0; i < 16; i++) begin
            preload(Q_BASE + 16'(2 * i), 16'(i));
            preload(ID_BASE + 16'(2 * i), 16'(i));
        end
        run_scan(7'd16, 1'b0);

        // All-equal pattern: first entry wins.
        for (int i = 0; i < 16; i++) begin
            preload(Q_BASE + 16'(2 * i), 16'h0042);
            preload(ID_BASE + 16'(2 * i), 16'h0100 + 16'(i));
        end
        run_scan(7'd16, 1'b0);

        // Zero count: no traffic, outputs unchanged.
        run_scan(7'd0, 1'b0);

        // Saturating count: maximum sits at entry 63, entry 64 also large.
        for (int i = 0; i < 65; i++) begin
            preload(Q_BASE + 16'(2 * i), (i >= 63) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE)));
            preload(ID_BASE + 16'(2 * i), 16'($urandom));
        end
        run_scan(7'd100, 1'b0);

        // Random patterns with many ties and random counts.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 64; i++) begin
                preload(Q_BASE + 16'(2 * i), 16'($urandom_range(0, 7)));
                preload(ID_BASE + 16'(2 * i), 16'($urandom));
            end
            run_scan(7'($urandom_range(1, 70)), 1'b0);
        end

        // Reset in the middle of a scan.
        preload(QOUT_ADDR, 16'hDEAD);
        preload(NEXT_ADDR, 16'hBEEF);
        begin
            int wr0;
            wr0   = wr_cnt;
            start = 1'b1;
            count = 7'd16;
            tick();
            start = 1'b0;
            for (int k = 0; k < 5; k++) tick();
            nrst = 1'b0;
            #1;
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
            check("abort_wr_en", {31'd0, mem_wr_en}, 32'd0);
            check("abort_addr", {16'd0, mem_addr}, 32'd0);
            check("abort_wdata", {16'd0, mem_wdata}, 32'd0);
            check("abort_best_idx", {26'd0, best_idx}, 32'd0);
            check("abort_best_q", {16'd0, best_q}, 32'd0);
            check("abort_best_id", {16'd0, best_id}, 32'd0);
            tick();
            tick();
            nrst = 1'b1;
            tick();
            check("abort_writes", wr_cnt - wr0, 32'd0);
            check("abort_mem_qout", {16'd0, rd(QOUT_ADDR)}, 32'h0000DEAD);
            check("abort_mem_next", {16'd0, rd(NEXT_ADDR)}, 32'h0000BEEF);
            m_idx = 6'd0;
            m_q   = 16'h0000;
            m_id  = 16'h0000;
        end
        run_scan(7'd16, 1'b0);

        // Start held high: no retrigger while busy, second scan from IDLE.
        run_scan(7'd10, 1'b1);
        run_scan(7'd16, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
